merge_sort_ctrl: RTL



---
 rtl/bwt_sort_pkg.sv | 23 ++
 rtl/merge_run_addr_gen.sv | 82 ++++++++
 rtl/merge_sort_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bwt_sort_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bwt_sort_pkg
// Brief    : Shared types and constants for the BWT suffix-sort merge control.
// Revision : 1.0 - initial release
// ============================================================================
package bwt_sort_pkg;

    localparam int ADDR_W_DEF = 4;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        NEXT   = 3'd3,
        FINISH = 3'd4
    } msc_state_t;

endpackage
`default_nettype wire

// File: rtl/merge_run_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : merge_run_addr_gen
// Brief    : Run base / length / pass / bank bookkeeping for bottom-up merge sort.
// Revision : 1.0 - initial release
// ============================================================================
module merge_run_addr_gen
    import bwt_sort_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    output logic [ADDR_W-1:0] left_base,
    output logic [ADDR_W-1:0] right_base,
    output logic [ADDR_W:0]   run_len,
    output logic [ADDR_W-1:0] pass_idx,
    output logic              src_bank,
    output logic              pass_end,
    output logic              sort_end
);

    localparam logic [ADDR_W:0] c_n_elem = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0]   r_base;
    logic [ADDR_W:0]   r_run_len;
    logic [ADDR_W-1:0] r_right;
    logic [ADDR_W-1:0] r_pass;
    logic              r_src;

    logic [ADDR_W:0]   w_span;
    logic [ADDR_W:0]   w_next_base;
    logic [ADDR_W:0]   w_next_len;

    // One extra bit lets base + 2*run_len reach N_ELEM without wrapping.
    always_comb begin
        w_span   = r_run_len << 1;
        pass_end = (r_base + w_span) >= c_n_elem;
        sort_end = (w_span == c_n_elem);
        if (pass_end) begin
            w_next_base = '0;
            w_next_len  = w_span;
        end else begin
            w_next_base = r_base + w_span;
            w_next_len  = r_run_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base    <= '0;
            r_run_len <= '0;
            r_right   <= '0;
            r_pass    <= '0;
            r_src     <= BANK_A;
        end else if (clear) begin
            r_base    <= '0;
            r_run_len <= (ADDR_W+1)'(1);
            r_right   <= ADDR_W'(1);
            r_pass    <= '0;
            r_src     <= BANK_A;
        end else if (step) begin
            r_base    <= w_next_base;
            r_run_len <= w_next_len;
            r_right   <= ADDR_W'(w_next_base + w_next_len);
            if (pass_end) begin
                r_pass <= r_pass + ADDR_W'(1);
                r_src  <= ~r_src;
            end
        end
    end

    assign left_base  = r_base[ADDR_W-1:0];
    assign right_base = r_right;
    assign run_len    = r_run_len;
    assign pass_idx   = r_pass;
    assign src_bank   = r_src;

endmodule
`default_nettype wire

// File: rtl/merge_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : merge_sort_ctrl
// Brief    : Pass/run scheduler driving the two-run merge engine over ping-pong
//            banks. Optional WAIT watchdog enabled by defining MERGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module merge_sort_ctrl
    import bwt_sort_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              merge_start,
    input  logic              merge_done,
    output logic [ADDR_W-1:0] left_base,
    output logic [ADDR_W-1:0] right_base,
    output logic [ADDR_W:0]   run_len,
    output logic              src_bank,
    output logic [ADDR_W-1:0] pass_idx,
    output logic              result_bank,
    output logic              timeout_err
);

    msc_state_t r_state;
    logic       w_clear;
    logic       w_step;
    logic       w_pass_end;
    logic       w_sort_end;

    assign w_clear = (r_state == IDLE) && start;
    assign w_step  = (r_state == NEXT);

    merge_run_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .step       (w_step),
        .left_base  (left_base),
        .right_base (right_base),
        .run_len    (run_len),
        .pass_idx   (pass_idx),
        .src_bank   (src_bank),
        .pass_end   (w_pass_end),
        .sort_end   (w_sort_end)
    );

`ifdef MERGE_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_timeout_err;

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    // Pulses are raised on the edge entering ISSUE/FINISH so they coincide
    // with the addresses the generator loads on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            merge_start   <= 1'b0;
            result_bank   <= BANK_A;
`ifdef MERGE_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            done          <= 1'b0;
            merge_start   <= 1'b0;
`ifdef MERGE_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= ISSUE;
                        busy        <= 1'b1;
                        merge_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
`ifdef MERGE_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                WAIT: begin
`ifdef MERGE_TIMEOUT_EN
                    if (merge_done) begin
                        r_state <= NEXT;
                    end else if (r_wait_cnt == c_cnt_last) begin
                        r_state       <= IDLE;
                        busy          <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
                    end
`else
                    if (merge_done) begin
                        r_state <= NEXT;
                    end
`endif
                end
                NEXT: begin
                    if (w_pass_end && w_sort_end) begin
                        r_state     <= FINISH;
                        done        <= 1'b1;
                        result_bank <= ~src_bank;
                    end else begin
                        r_state     <= ISSUE;
                        merge_start <= 1'b1;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
